// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: drives pll_rst, qualifies locked, releases sys_rst.
// Optional LOCK_LOSS_COUNT_EN adds a saturating lock_loss_cnt output.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  input  logic        soft_restart,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        pll_ready,
  output logic        fail,
  output logic [2:0]  retry_cnt
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [15:0] lock_loss_cnt
`endif
);

  localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [2:0]          retry_d;
  logic [2:0]          retry_inc;
  logic                timeout;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                lk_s;

  // locked crosses in from the PLL domain
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

  // next-state and counter updates
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    to_cnt_d   = to_cnt_q;
    stab_cnt_d = stab_cnt_q;
    retry_d    = retry_cnt;
    retry_inc  = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
    timeout    = ((state_q == WAIT_LOCK) || (state_q == STABILIZE)) &&
                 (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1));

    if (soft_restart) begin
      state_d    = RESET_PLL;
      rst_cnt_d  = '0;
      to_cnt_d   = '0;
      stab_cnt_d = '0;
      retry_d    = 3'd0;
    end else if (timeout) begin
      retry_d    = retry_inc;
      state_d    = (retry_inc == 3'(MAX_RETRIES)) ? FAIL : RESET_PLL;
      rst_cnt_d  = '0;
      stab_cnt_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
            state_d   = WAIT_LOCK;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        WAIT_LOCK: begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (lk_s) begin
            state_d    = STABILIZE;
            stab_cnt_d = '0;
          end
        end
        STABILIZE: begin
          // timeout keeps running across lock drops within one attempt
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (!lk_s) begin
            state_d = WAIT_LOCK;
          end else if (stab_cnt_q == STAB_W'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
          end else begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d    = RESET_PLL;
            rst_cnt_d  = '0;
            stab_cnt_d = '0;
            retry_d    = 3'd0;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = RESET_PLL;
        end
      endcase
    end
  end

  // state, counters and outputs decoded from the next state
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= RESET_PLL;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stab_cnt_q <= '0;
      retry_cnt  <= 3'd0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      pll_ready  <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      retry_cnt  <= retry_d;
      pll_rst    <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst    <= (state_d != RUN);
      pll_ready  <= (state_d == RUN);
      fail       <= (state_d == FAIL);
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  // lock-loss events survive soft_restart
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt <= 16'h0000;
    end else if ((state_q == RUN) && !lk_s && !soft_restart &&
                 (lock_loss_cnt != 16'hFFFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
  end
`endif

endmodule
